// File: rtl/clock.sv
// clock: 24-hour time-of-day counter with a one-second prescaler and packed BCD outputs.
// Define CLOCK_ALARM_EN to build in the latched HH:MM alarm comparator.
`timescale 1ns/1ps
module clock #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SET,
  input  logic [4:0] SET_H,
  input  logic [5:0] SET_M,
  input  logic       ALM_SET,
  input  logic       ALM_CLR,
  output logic [4:0] HH,
  output logic [5:0] MM,
  output logic [5:0] SS,
  output logic [7:0] HH_BCD,
  output logic [7:0] MM_BCD,
  output logic [7:0] SS_BCD,
  output logic       TICK,
  output logic       ALARM
);
  localparam int PC_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(TICKS_PER_SEC - 1);

  logic [PC_W-1:0] r_pc;
  logic [4:0]      r_hh;
  logic [5:0]      r_mm;
  logic [5:0]      r_ss;
  logic            r_tick;

  logic            w_last;
  logic            w_set_ok;
  logic            w_load;
  logic            w_advance;
  logic            w_ss_wrap;
  logic            w_mm_wrap;
  logic [4:0]      w_hh_nx;
  logic [5:0]      w_mm_nx;
  logic [5:0]      w_ss_nx;

  assign w_last    = (r_pc == PC_LAST);
  assign w_set_ok  = (SET_H <= 5'd23) && (SET_M <= 6'd59);
  assign w_load    = SET && w_set_ok;
  // A valid load swallows a coincident second boundary.
  assign w_advance = w_last && !w_load;
  assign w_ss_wrap = (r_ss == 6'd59);
  assign w_mm_wrap = (r_mm == 6'd59);

  always_comb begin
    w_ss_nx = w_ss_wrap ? 6'd0 : r_ss + 6'd1;
    w_mm_nx = r_mm;
    w_hh_nx = r_hh;
    if (w_ss_wrap) begin
      w_mm_nx = w_mm_wrap ? 6'd0 : r_mm + 6'd1;
      if (w_mm_wrap) begin
        w_hh_nx = (r_hh == 5'd23) ? 5'd0 : r_hh + 5'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc   <= '0;
      r_hh   <= '0;
      r_mm   <= '0;
      r_ss   <= '0;
      r_tick <= 1'b0;
    end else if (w_load) begin
      r_hh   <= SET_H;
      r_mm   <= SET_M;
      r_ss   <= '0;
      r_pc   <= '0;
      r_tick <= 1'b0;
    end else if (w_advance) begin
      r_pc   <= '0;
      r_tick <= 1'b1;
      r_ss   <= w_ss_nx;
      r_mm   <= w_mm_nx;
      r_hh   <= w_hh_nx;
    end else begin
      r_pc   <= r_pc + PC_W'(1);
      r_tick <= 1'b0;
    end
  end

  assign HH   = r_hh;
  assign MM   = r_mm;
  assign SS   = r_ss;
  assign TICK = r_tick;

  logic [5:0] w_bin [3];
  logic [7:0] w_bcd [3];

  assign w_bin[0] = {1'b0, r_hh};
  assign w_bin[1] = r_mm;
  assign w_bin[2] = r_ss;

  for (genvar gi = 0; gi < 3; gi++) begin : g_bcd
    logic [3:0] w_tens;
    logic [3:0] w_units;
    assign w_tens     = 4'(w_bin[gi] / 6'd10);
    assign w_units    = 4'(w_bin[gi] % 6'd10);
    assign w_bcd[gi]  = {w_tens, w_units};
  end

  assign HH_BCD = w_bcd[0];
  assign MM_BCD = w_bcd[1];
  assign SS_BCD = w_bcd[2];

`ifdef CLOCK_ALARM_EN
  logic [4:0] r_alm_h;
  logic [5:0] r_alm_m;
  logic       r_alarm;
  logic       w_hit;

  // Match only on a real second boundary so a load onto the alarm time stays silent.
  assign w_hit = w_advance && (w_ss_nx == 6'd0) &&
                 (w_mm_nx == r_alm_m) && (w_hh_nx == r_alm_h);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_alm_h <= '0;
      r_alm_m <= '0;
      r_alarm <= 1'b0;
    end else begin
      if (ALM_SET && w_set_ok) begin
        r_alm_h <= SET_H;
        r_alm_m <= SET_M;
      end
      if (ALM_CLR) begin
        r_alarm <= 1'b0;
      end else if (w_hit) begin
        r_alarm <= 1'b1;
      end
    end
  end

  assign ALARM = r_alarm;
`else
  logic w_unused_alm;
  assign w_unused_alm = ALM_SET ^ ALM_CLR;
  assign ALARM        = 1'b0;
`endif

endmodule

// File: tb/tb_clock.sv
// tb_clock: scoreboard bench for the clock block; expected times are queued per second and
// popped whenever TICK is seen.
`timescale 1ns/1ps
module tb_clock;
  localparam int TPS = 4;
`ifdef CLOCK_ALARM_EN
  localparam bit ALM_EN = 1'b1;
`else
  localparam bit ALM_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SET = 1'b0;
  logic [4:0] SET_H = '0;
  logic [5:0] SET_M = '0;
  logic       ALM_SET = 1'b0;
  logic       ALM_CLR = 1'b0;
  logic [4:0] HH;
  logic [5:0] MM;
  logic [5:0] SS;
  logic [7:0] HH_BCD;
  logic [7:0] MM_BCD;
  logic [7:0] SS_BCD;
  logic       TICK;
  logic       ALARM;

  clock #(.TICKS_PER_SEC(TPS)) dut (
    .CLK(CLK), .RST(RST), .SET(SET), .SET_H(SET_H), .SET_M(SET_M),
    .ALM_SET(ALM_SET), .ALM_CLR(ALM_CLR),
    .HH(HH), .MM(MM), .SS(SS),
    .HH_BCD(HH_BCD), .MM_BCD(MM_BCD), .SS_BCD(SS_BCD),
    .TICK(TICK), .ALARM(ALARM)
  );

  always #100 CLK = ~CLK;

  typedef struct {
    int hh;
    int mm;
    int ss;
    bit alm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_pass = 0;
  int   tick_cnt = 0;
  int   cur_h = 0, cur_m = 0, cur_s = 0;
  int   alm_h = 0, alm_m = 0;
  bit   exp_alm = 1'b0;
  int   n_edges;
  int   n_bad;

  function automatic int bcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  task automatic check(input string tag, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, want, want);
  endtask

  task automatic push_ticks(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      cur_s++;
      if (cur_s == 60) begin
        cur_s = 0;
        cur_m++;
        if (cur_m == 60) begin
          cur_m = 0;
          cur_h = (cur_h + 1) % 24;
        end
      end
      if (ALM_EN && cur_s == 0 && cur_m == alm_m && cur_h == alm_h) exp_alm = 1'b1;
      e.hh = cur_h; e.mm = cur_m; e.ss = cur_s; e.alm = exp_alm;
      sb.push_back(e);
    end
  endtask

  // Scoreboard consumer: one pop per observed second boundary.
  always @(negedge CLK) begin
    if (!RST && TICK) begin
      tick_cnt = tick_cnt + 1;
      if (sb.size() == 0) begin
        check("tick_unexpected", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("tick_hh", int'(HH), mon_e.hh);
        check("tick_mm", int'(MM), mon_e.mm);
        check("tick_ss", int'(SS), mon_e.ss);
        check("tick_hh_bcd", int'(HH_BCD), bcd(mon_e.hh));
        check("tick_mm_bcd", int'(MM_BCD), bcd(mon_e.mm));
        check("tick_ss_bcd", int'(SS_BCD), bcd(mon_e.ss));
        check("tick_alarm", int'(ALARM), int'(mon_e.alm));
      end
    end
  end

  task automatic wait_ticks(input int n);
    int target;
    target = tick_cnt + n;
    for (int k = 0; k < n * TPS + 8 && tick_cnt < target; k++) begin
      @(negedge CLK); #1;
    end
    if (tick_cnt < target) check("tick_timeout", tick_cnt, target);
  endtask

  task automatic edges_to_tick(output int n);
    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (!TICK && n < 3 * TPS);
    @(negedge CLK); #1;
  endtask

  task automatic load(input int h, input int m);
    SET_H = 5'(h);
    SET_M = 6'(m);
    SET   = 1'b1;
    @(posedge CLK); #1;
    SET   = 1'b0;
    cur_h = h; cur_m = m; cur_s = 0;
  endtask

  initial begin
    // Reset state
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_hh", int'(HH), 0);
    check("rst_mm", int'(MM), 0);
    check("rst_ss", int'(SS), 0);
    check("rst_tick", int'(TICK), 0);
    check("rst_ss_bcd", int'(SS_BCD), 0);
    check("rst_alarm", int'(ALARM), 0);

    // First tick latency and period
    push_ticks(1);
    RST = 1'b0;
    edges_to_tick(n_edges);
    check("first_tick_edges", n_edges, TPS);
    push_ticks(3);
    for (int i = 0; i < 3; i++) begin
      edges_to_tick(n_edges);
      check("tick_period", n_edges, TPS);
    end

    // Carry through midnight
    load(23, 59);
    check("load_hh", int'(HH), 23);
    check("load_mm", int'(MM), 59);
    check("load_ss", int'(SS), 0);
    check("load_hh_bcd", int'(HH_BCD), 'h23);
    check("load_mm_bcd", int'(MM_BCD), 'h59);
    check("load_tick", int'(TICK), 0);
    push_ticks(60);
    wait_ticks(60);
    check("carry_drain", sb.size(), 0);
    check("midnight_hh", int'(HH), 0);

    // Rejected loads leave time and prescaler alone
    load(1, 2);
    push_ticks(3);
    wait_ticks(3);
    SET_H = 5'd24; SET_M = 6'd2; SET = 1'b1;
    @(posedge CLK); #1;
    SET = 1'b0;
    check("inv_h_hh", int'(HH), 1);
    check("inv_h_ss", int'(SS), 3);
    push_ticks(1);
    edges_to_tick(n_edges);
    check("inv_h_pc_kept", n_edges, TPS - 1);
    SET_H = 5'd1; SET_M = 6'd60; SET = 1'b1;
    @(posedge CLK); #1;
    SET = 1'b0;
    check("inv_m_mm", int'(MM), 2);
    check("inv_m_ss", int'(SS), 4);
    push_ticks(1);
    edges_to_tick(n_edges);
    check("inv_m_pc_kept", n_edges, TPS - 1);

    // SET on the tick edge, then held to freeze
    repeat (TPS - 1) begin
      @(posedge CLK); #1;
    end
    SET_H = 5'd5; SET_M = 6'd6; SET = 1'b1;
    @(posedge CLK); #1;
    check("set_on_tick_tick", int'(TICK), 0);
    check("set_on_tick_hh", int'(HH), 5);
    check("set_on_tick_mm", int'(MM), 6);
    check("set_on_tick_ss", int'(SS), 0);
    n_bad = 0;
    repeat (2 * TPS) begin
      @(posedge CLK); #1;
      if (TICK || SS != 6'd0) n_bad++;
    end
    check("set_hold_frozen", n_bad, 0);
    SET = 1'b0;
    cur_h = 5; cur_m = 6; cur_s = 0;
    push_ticks(1);
    edges_to_tick(n_edges);
    check("set_release_edges", n_edges, TPS);

    // Alarm at 00:01 from reset
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst2_alarm", int'(ALARM), 0);
    check("rst2_ss", int'(SS), 0);
    cur_h = 0; cur_m = 0; cur_s = 0;
    exp_alm = 1'b0; alm_h = 0; alm_m = 1;
    SET_H = 5'd0; SET_M = 6'd1; ALM_SET = 1'b1;
    push_ticks(62);
    RST = 1'b0;
    @(posedge CLK); #1;
    ALM_SET = 1'b0;
    wait_ticks(62);
    check("alarm_drain", sb.size(), 0);
    check("alarm_held", int'(ALARM), int'(ALM_EN));
    ALM_CLR = 1'b1;
    @(posedge CLK); #1;
    ALM_CLR = 1'b0;
    exp_alm = 1'b0;
    check("alm_clr", int'(ALARM), 0);
    load(0, 1);
    check("set_on_alarm_time", int'(ALARM), 0);
    push_ticks(1);
    wait_ticks(1);

    check("sb_final", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
